// File: rtl/calc_density_accum.sv
// SPH density accumulator: per-pair kernel term MASS*max(0, H-|ri-rj|) summed per particle.
// Contains the binary16 arithmetic units it is built from; subnormals flush to zero.

module fp16_pipe #(
  parameter int LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] d,
  input  logic        v,
  output logic [15:0] q,
  output logic        qv
);
  logic [15:0]    pd [LAT];
  logic [LAT-1:0] pv;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= 16'h0000;
    end else begin
      pv[0] <= v;
      pd[0] <= d;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign q  = pd[LAT-1];
  assign qv = pv[LAT-1];
endmodule

module binary16_adder #(
  parameter int LAT = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic [15:0] result,
  output logic        data_valid_out
);
  function automatic logic [15:0] fp_add(input logic [15:0] x_in, input logic [15:0] y_in);
    logic [15:0] x, y;
    logic [13:0] mx, my, ms;
    logic [14:0] s;
    logic [11:0] mr;
    logic [4:0]  d;
    logic        rnd;
    int          e;
    if (x_in[14:0] >= y_in[14:0]) begin
      x = x_in; y = y_in;
    end else begin
      x = y_in; y = x_in;
    end
    mx = (x[14:10] == 5'd0) ? 14'd0 : {1'b1, x[9:0], 3'b000};
    my = (y[14:10] == 5'd0) ? 14'd0 : {1'b1, y[9:0], 3'b000};
    if (mx == 14'd0) return 16'h0000;
    d = x[14:10] - y[14:10];
    // Aligned smaller operand keeps the shifted-out bits as a sticky LSB
    if (d > 5'd13) ms = {13'd0, |my};
    else ms = (my >> d) | {13'd0, |(my & ((14'd1 << d) - 14'd1))};
    e = int'(x[14:10]);
    if (x[15] == y[15]) begin
      s = {1'b0, mx} + {1'b0, ms};
      if (s[14]) begin
        s = {1'b0, s[14:1]} | {14'd0, s[0]};
        e = e + 1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, ms};
      if (s == 15'd0) return 16'h0000;
      for (int i = 0; i < 13; i++) begin
        if (!s[13]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    mr  = {1'b0, s[13:3]} + {11'd0, rnd};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e <= 0) return 16'h0000;
    if (e >= 31) return {x[15], 15'h7C00};
    return {x[15], 5'(e), mr[9:0]};
  endfunction

  logic [15:0] sum_c;
  assign sum_c = fp_add(a, b);

  fp16_pipe #(.LAT(LAT)) u_pipe (
    .clk_in(clk_in), .rst(rst), .d(sum_c), .v(data_valid_in),
    .q(result), .qv(data_valid_out)
  );
endmodule

module binary16_multi #(
  parameter int LAT = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic [15:0] result,
  output logic        data_valid_out
);
  function automatic logic [15:0] fp_mul(input logic [15:0] x, input logic [15:0] y);
    logic [21:0] p;
    logic [10:0] m;
    logic [11:0] mr;
    logic        g, st, sg;
    int          e;
    sg = x[15] ^ y[15];
    if (x[14:10] == 5'd0 || y[14:10] == 5'd0) return {sg, 15'h0000};
    p = {11'd0, 1'b1, x[9:0]} * {11'd0, 1'b1, y[9:0]};
    e = int'(x[14:10]) + int'(y[14:10]) - 15;
    if (p[21]) begin
      m = p[21:11]; g = p[10]; st = |p[9:0]; e = e + 1;
    end else begin
      m = p[20:10]; g = p[9];  st = |p[8:0];
    end
    mr = {1'b0, m} + {11'd0, g & (st | m[0])};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e <= 0) return {sg, 15'h0000};
    if (e >= 31) return {sg, 15'h7C00};
    return {sg, 5'(e), mr[9:0]};
  endfunction

  logic [15:0] prod_c;
  assign prod_c = fp_mul(a, b);

  fp16_pipe #(.LAT(LAT)) u_pipe (
    .clk_in(clk_in), .rst(rst), .d(prod_c), .v(data_valid_in),
    .q(result), .qv(data_valid_out)
  );
endmodule

module binary16_sqrt #(
  parameter int LAT = 3
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        data_valid_in,
  output logic [15:0] result,
  output logic        data_valid_out
);
  function automatic logic [15:0] fp_sqrt(input logic [15:0] x);
    logic [31:0] r;
    logic [17:0] rem, trial;
    logic [15:0] q;
    logic [11:0] mr;
    logic [5:0]  e6;
    logic [4:0]  e;
    logic        rnd;
    if (x[14:10] == 5'd0 || x[15]) return 16'h0000;
    // Odd biased exponent means an even true exponent; the radicand always yields a root in [2^15, 2^16)
    r = x[10] ? {1'b0, 1'b1, x[9:0], 20'd0} : {1'b1, x[9:0], 21'd0};
    rem = 18'd0;
    q   = 16'd0;
    for (int i = 0; i < 16; i++) begin
      rem   = {rem[15:0], r[31:30]};
      r     = r << 2;
      trial = {q, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        q   = {q[14:0], 1'b1};
      end else begin
        q   = {q[14:0], 1'b0};
      end
    end
    e6  = ({1'b0, x[14:10]} + 6'd15) >> 1;
    e   = e6[4:0];
    rnd = q[4] & ((|q[3:0]) | (rem != 18'd0) | q[5]);
    mr  = {1'b0, q[15:5]} + {11'd0, rnd};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 5'd1;
    end
    return {1'b0, e, mr[9:0]};
  endfunction

  logic [15:0] root_c;
  assign root_c = fp_sqrt(a);

  fp16_pipe #(.LAT(LAT)) u_pipe (
    .clk_in(clk_in), .rst(rst), .d(root_c), .v(data_valid_in),
    .q(result), .qv(data_valid_out)
  );
endmodule

// Accumulator FSM
//   state  | meaning
//   S_IDLE | waiting for a buffered term; pops and issues acc + w
//   S_WAIT | accumulation adder in flight
//   S_EMIT | density pulse presented; acc cleared for the next particle
module calc_density_accum #(
  parameter int          DIMS       = 3,
  parameter logic [15:0] H          = 16'h3C00,
  parameter logic [15:0] MASS       = 16'h3C00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [16*DIMS-1:0] r_i,
  input  logic [16*DIMS-1:0] r_j,
  input  logic               data_valid_in,
  input  logic               last_in,
  output logic               ready_out,
  output logic [15:0]        result,
  output logic               data_valid_out,
  output logic               busy
);
  localparam int A   = 2;
  localparam int M   = 2;
  localparam int S   = 3;
  localparam int L_F = A + M + $clog2(DIMS) * A + S + A + M + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int IW  = PW + 1;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_t;

  logic accept;
  assign accept = data_valid_in & ready_out;

  logic [15:0]     diff [DIMS];
  logic [15:0]     sq   [DIMS];
  logic [DIMS-1:0] diff_v, sq_v;

  for (genvar d = 0; d < DIMS; d++) begin : g_dim
    binary16_adder #(.LAT(A)) u_diff (
      .clk_in(clk_in), .rst(rst), .a(r_i[16*d +: 16]), .b(r_j[16*d +: 16] ^ 16'h8000),
      .data_valid_in(accept), .result(diff[d]), .data_valid_out(diff_v[d])
    );
    binary16_multi #(.LAT(M)) u_sq (
      .clk_in(clk_in), .rst(rst), .a(diff[d]), .b(diff[d]),
      .data_valid_in(diff_v[d]), .result(sq[d]), .data_valid_out(sq_v[d])
    );
  end

  logic [15:0] ssq;
  logic        ssq_v;

  if (DIMS == 1) begin : g_sum1
    assign ssq   = sq[0];
    assign ssq_v = &sq_v;
  end else if (DIMS == 2) begin : g_sum2
    binary16_adder #(.LAT(A)) u_add01 (
      .clk_in(clk_in), .rst(rst), .a(sq[0]), .b(sq[1]),
      .data_valid_in(&sq_v), .result(ssq), .data_valid_out(ssq_v)
    );
  end else begin : g_sum3
    logic [15:0] s01, sq2_d;
    logic        s01_v, sq2_dv;
    binary16_adder #(.LAT(A)) u_add01 (
      .clk_in(clk_in), .rst(rst), .a(sq[0]), .b(sq[1]),
      .data_valid_in(&sq_v), .result(s01), .data_valid_out(s01_v)
    );
    // sq_2 waits out the first adder so both reach the second adder together
    fp16_pipe #(.LAT(A)) u_sq2_dly (
      .clk_in(clk_in), .rst(rst), .d(sq[2]), .v(&sq_v), .q(sq2_d), .qv(sq2_dv)
    );
    binary16_adder #(.LAT(A)) u_add012 (
      .clk_in(clk_in), .rst(rst), .a(s01), .b(sq2_d),
      .data_valid_in(s01_v & sq2_dv), .result(ssq), .data_valid_out(ssq_v)
    );
  end

  logic [15:0] rr, kk, clamp_k, w;
  logic        rr_v, kk_v, clamp_v, w_v;

  binary16_sqrt #(.LAT(S)) u_sqrt (
    .clk_in(clk_in), .rst(rst), .a(ssq),
    .data_valid_in(ssq_v), .result(rr), .data_valid_out(rr_v)
  );

  binary16_adder #(.LAT(A)) u_kern (
    .clk_in(clk_in), .rst(rst), .a(H), .b(rr | 16'h8000),
    .data_valid_in(rr_v), .result(kk), .data_valid_out(kk_v)
  );

  // Negative kernel (outside the radius) and -0 both become +0
  always_ff @(posedge clk_in) begin
    if (rst) begin
      clamp_v <= 1'b0;
      clamp_k <= 16'h0000;
    end else begin
      clamp_v <= kk_v;
      clamp_k <= kk[15] ? 16'h0000 : kk;
    end
  end

  binary16_multi #(.LAT(M)) u_mass (
    .clk_in(clk_in), .rst(rst), .a(MASS), .b(clamp_k),
    .data_valid_in(clamp_v), .result(w), .data_valid_out(w_v)
  );

  logic [L_F-1:0] last_dl;
  always_ff @(posedge clk_in) begin
    if (rst) last_dl <= '0;
    else     last_dl <= {last_dl[L_F-2:0], accept & last_in};
  end

  logic [16:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] fifo_count, inflight;
  logic [16:0]   head;
  logic          fifo_push, fifo_pop;
  state_t        state;

  assign fifo_push = w_v;
  assign fifo_pop  = (state == S_IDLE) && (fifo_count != '0);
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (fifo_push) fifo_mem[wr_ptr] <= {last_dl[L_F-1], w};
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + {{(IW-1){1'b0}}, fifo_push} - {{(IW-1){1'b0}}, fifo_pop};
      inflight   <= inflight + {{(IW-1){1'b0}}, accept} - {{(IW-1){1'b0}}, fifo_push};
    end
  end

  // Credits reserve a FIFO slot for every pair still in the front pipeline
  assign ready_out = !rst && (({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_W);

  a_no_overflow: assert property (@(posedge clk_in) disable iff (rst)
    !(fifo_push && fifo_count == IW'(FIFO_DEPTH)));

  logic [15:0] acc, acc_sum;
  logic        acc_v, cur_last;

  binary16_adder #(.LAT(A)) u_acc (
    .clk_in(clk_in), .rst(rst), .a(acc), .b(head[15:0]),
    .data_valid_in(fifo_pop), .result(acc_sum), .data_valid_out(acc_v)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state          <= S_IDLE;
      acc            <= 16'h0000;
      cur_last       <= 1'b0;
      result         <= 16'h0000;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            cur_last <= head[16];
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (acc_v) begin
            acc <= acc_sum;
            if (cur_last) begin
              result         <= acc_sum;
              data_valid_out <= 1'b1;
              state          <= S_EMIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_EMIT: begin
          acc   <= 16'h0000;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (inflight != '0) || (fifo_count != '0) || (state != S_IDLE);
endmodule

// File: tb/tb_calc_density_accum.sv
// Directed bench for calc_density_accum: scoreboard queues filled by the driver, drained by per-DUT monitors.
module tb_calc_density_accum;
  localparam int LAT3 = 20;  // L_F=16 (A=2,M=2,S=3,DIMS=3) + A + 2
  localparam int LAT1 = 16;  // L_F=12 for DIMS=1

  typedef struct {
    logic [15:0] val;
    int          c0;
    bit          chk_lat;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit saw_stall = 0;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [47:0] ri3, rj3;
  logic        dvi3, last3;
  logic        ready3, dvo3, busy3;
  logic [15:0] res3;
  logic [15:0] ri1, rj1;
  logic        dvi1, last1;
  logic        ready1, dvo1, busy1;
  logic [15:0] res1;

  calc_density_accum u_dut3 (
    .clk_in(clk_in), .rst(rst), .r_i(ri3), .r_j(rj3),
    .data_valid_in(dvi3), .last_in(last3), .ready_out(ready3),
    .result(res3), .data_valid_out(dvo3), .busy(busy3)
  );

  calc_density_accum #(.DIMS(1), .MASS(16'h4000)) u_dut1 (
    .clk_in(clk_in), .rst(rst), .r_i(ri1), .r_j(rj1),
    .data_valid_in(dvi1), .last_in(last1), .ready_out(ready1),
    .result(res1), .data_valid_out(dvo1), .busy(busy1)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk_in);
    if (dvo3) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL dut3_unexpected_pulse actual=%h required=none", res3);
      end else begin
        e = q3.pop_front();
        check("dut3_result", res3, e.val);
        if (e.chk_lat) check_int("dut3_latency", cyc - e.c0, LAT3);
      end
    end
    if (dvo1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_pulse actual=%h required=none", res1);
      end else begin
        e = q1.pop_front();
        check("dut1_result", res1, e.val);
        if (e.chk_lat) check_int("dut1_latency", cyc - e.c0, LAT1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the pair was taken
  task automatic send3(input logic [47:0] ri, input logic [47:0] rj, input logic last, output int c0);
    int guard = 0;
    ri3 = ri; rj3 = rj; last3 = last; dvi3 = 1'b1;
    while (!ready3 && guard < 500) begin
      saw_stall = 1;
      @(negedge clk_in);
      guard++;
    end
    if (!ready3) begin
      total++; bad++;
      $display("FAIL dut3_accept_timeout actual=ready0 required=ready1");
    end
    c0 = cyc;
    @(negedge clk_in);
    dvi3 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] ri, input logic [15:0] rj, input logic last, output int c0);
    int guard = 0;
    ri1 = ri; rj1 = rj; last1 = last; dvi1 = 1'b1;
    while (!ready1 && guard < 500) begin
      @(negedge clk_in);
      guard++;
    end
    if (!ready1) begin
      total++; bad++;
      $display("FAIL dut1_accept_timeout actual=ready0 required=ready1");
    end
    c0 = cyc;
    @(negedge clk_in);
    dvi1 = 1'b0;
  endtask

  task automatic drain3(input int limit, input string name);
    int n = 0;
    while (q3.size() != 0 && n < limit) begin
      @(negedge clk_in);
      n++;
    end
    check_int({name, "_drained"}, q3.size(), 0);
    @(negedge clk_in);
    check({name, "_busy_low"}, {15'd0, busy3}, 16'h0000);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    ri3 = '0; rj3 = '0; dvi3 = 1'b0; last3 = 1'b0;
    ri1 = '0; rj1 = '0; dvi1 = 1'b0; last1 = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    check("reset_ready", {15'd0, ready3}, 16'h0001);
    check("reset_dvo", {15'd0, dvo3}, 16'h0000);
    check("reset_result", res3, 16'h0000);
    check("reset_busy", {15'd0, busy3}, 16'h0000);
    check("reset_ready_dims1", {15'd0, ready1}, 16'h0001);

    // single pair inside radius: 1 - 0.5
    send3(48'h0, 48'h0000_0000_3800, 1'b1, c0);
    q3.push_back('{16'h3800, c0, 1'b1});
    drain3(200, "single");

    // outside radius clamps to zero
    send3(48'h0, 48'h0000_0000_3E00, 1'b1, c0);
    q3.push_back('{16'h0000, c0, 1'b1});
    drain3(200, "clamp");

    // 1.0 + 0.5 + 0.75
    send3(48'h0, 48'h0000_0000_0000, 1'b0, c0);
    send3(48'h0, 48'h0000_0000_3800, 1'b0, c0);
    send3(48'h0, 48'h3400_0000_0000, 1'b1, c0);
    q3.push_back('{16'h4080, c0, 1'b0});
    drain3(300, "group3");

    saw_stall = 0;
    for (int g = 0; g < 10; g++) begin
      send3(48'h0, 48'h0000_0000_3800, 1'b0, c0);
      send3(48'h0, 48'h0000_0000_3800, 1'b1, c0);
      q3.push_back('{16'h3C00, c0, 1'b0});
    end
    check("backpressure_stall", {15'd0, saw_stall}, 16'h0001);
    drain3(2000, "backpressure");

    // partial group discarded by reset
    send3(48'h0, 48'h0000_0000_3800, 1'b0, c0);
    send3(48'h0, 48'h0000_0000_3800, 1'b0, c0);
    rst = 1'b1;
    @(negedge clk_in);
    check("midrst_ready", {15'd0, ready3}, 16'h0000);
    check("midrst_dvo", {15'd0, dvo3}, 16'h0000);
    check("midrst_result", res3, 16'h0000);
    check("midrst_busy", {15'd0, busy3}, 16'h0000);
    rst = 1'b0;
    repeat (40) @(negedge clk_in);
    send3(48'h0, 48'h0000_0000_3800, 1'b1, c0);
    q3.push_back('{16'h3800, c0, 1'b1});
    drain3(200, "after_reset");

    // DIMS=1, MASS=2.0: 2 * (1 - 0.25)
    send1(16'h3C00, 16'h3D00, 1'b1, c0);
    q1.push_back('{16'h3E00, c0, 1'b1});
    for (int n = 0; n < 200 && q1.size() != 0; n++) @(negedge clk_in);
    check_int("dims1_drained", q1.size(), 0);
    @(negedge clk_in);
    check("dims1_busy_low", {15'd0, busy1}, 16'h0000);

    repeat (30) @(negedge clk_in);
    check_int("final_q3_empty", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_density_accum.md
# calc_density_accum

Multi-dimensional SPH density accumulator for the particle simulator.
- Accepts a stream of (r_i, r_j) neighbour pairs, each DIMS binary16 coordinates wide.
- For each pair, computes the kernel term w = MASS · max(0, H − |r_i − r_j|).
- Sums the terms over every pair tagged to the same particle i and emits one binary16 density per particle.
- Sits between the neighbour-pair generator and the pressure stage. It is built from the existing binary16_adder, binary16_multi and binary16_sqrt units.

## Interface
- DIMS, 3, number of coordinate dimensions (1..3).
- H, 16'h3C00, smoothing radius as binary16 (1.0).
- MASS, 16'h3C00, particle mass as binary16 (1.0).
- FIFO_DEPTH, 8, kernel-term buffer depth (power of two, ≥2).

Ports:
- clk_in  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- r_i  in  16*DIMS  particle i position; dimension d is bits [16d+15:16d].
- r_j  in  16*DIMS  neighbour j position, same packing.
- data_valid_in  in  1  pair valid.
- last_in  in  1  marks the final pair for the current particle i; qualified by data_valid_in.
- ready_out  out  1  block can accept a pair this cycle.
- result  out  16  accumulated binary16 density.
- data_valid_out  out  1  one-cycle pulse; result is valid.
- busy  out  1  any pair in flight, any term buffered, or accumulator non-idle.

## Operation
- Accept: a pair is accepted when data_valid_in && ready_out. Pairs presented while ready_out=0 are ignored; the upstream block must hold them.
- Front pipeline (fully pipelined, one pair per cycle, last_in carried alongside in a matched delay line):
  - per dimension: diff_d = r_i[d] + (r_j[d] ^ 16'h8000), then sq_d = diff_d · diff_d;
  - sum of squares: DIMS=1 passes sq_0 through; DIMS=2 uses one adder; DIMS=3 computes (sq_0+sq_1)+sq_2, with sq_2 delayed by one adder latency;
  - r = sqrt(sum); k = H + (r | 16'h8000);
  - clamp: if k[15]=1 then k = 16'h0000 (this also turns −0 into +0);
  - w = MASS · k.
- Every operand path is delay-matched so that valid, last and data stay aligned. No bubbles are inserted.
- Credit counter inflight (width clog2(FIFO_DEPTH)+1):
  - +1 on accept, −1 when w enters the FIFO;
  - ready_out = (inflight + fifo_count) < FIFO_DEPTH;
  - the FIFO therefore never overflows. Writing while full is a design error and must be covered by an assertion.
- FIFO entries are {last, w}. A push and a pop in the same cycle are legal and leave the count unchanged.
- Accumulator FSM; acc register starts at +0:
  - IDLE: when the FIFO is non-empty, pop one entry and issue acc + w to the shared accumulator adder → WAIT.
  - WAIT: when the adder's data_valid_out arrives, acc ← sum. If the entry was tagged last → EMIT; otherwise → IDLE.
  - EMIT: result ← acc, data_valid_out=1 for this cycle, acc ← 16'h0000 → IDLE.
- Only one accumulation is in flight at a time, so there is no read-after-write hazard on acc.
- A group containing a single pair is legal. Inputs with NaN/Inf are unsupported; the output for them is undefined but must not hang the FSM.
- Reset, including mid-operation:
  - rst is routed to all submodules;
  - front-pipeline valids, inflight, FIFO pointers and count, acc and FSM state are all cleared;
  - all partial sums and in-flight pairs are discarded.

## Timing
- Reset values: result=16'h0000, data_valid_out=0, ready_out=1 (from the cycle after rst deasserts), busy=0.
- Latency terms:
  - L_F = A + M + ceil(log2 DIMS)·A + S + A + M + 1 cycles, from accept to FIFO write. A, M and S are the adder, multiplier and sqrt latencies.
  - Expose L_F as a localparam.
- Accumulation rate: one term per A+1 cycles.
- A last-tagged term that finds the FSM in IDLE with an empty FIFO produces data_valid_out exactly L_F + A + 2 cycles after its pair is accepted.
- Sustained input rate is therefore bounded by the accumulator. ready_out deasserts once inflight + fifo_count reaches FIFO_DEPTH.
- Results leave in the same order as the groups arrived.

## Test plan
All cases use DIMS=3, H=1.0, MASS=1.0, r_i=(0,0,0) unless stated.
- Single pair, r_j=(16'h3800,0,0), last=1 → one pulse, result=16'h3800 (0.5), at the L_F+A+2 latency; busy then falls to 0.
- Out-of-range pair, r_j=(16'h3E00,0,0) (1.5), last=1 → result=16'h0000 (clamp path).
- Group of three: r_j=(0,0,0), (16'h3800,0,0), (0,0,16'h3400), with last on the third only → exactly one pulse, result=16'h4080 (2.25).
- Back-pressure: data_valid_in held high for 20 pairs in 10 groups of two, each pair r_j=(16'h3800,0,0).
  - Required: ready_out deasserts while the buffer is full;
  - exactly 10 pulses, in order, each result=16'h3C00;
  - the FIFO-overflow assertion never fires.
- Reset mid-group: send two non-last pairs, pulse rst for 1 cycle, then send the single-pair case.
  - Required: outputs are 0 during reset and the only pulse is result=16'h3800.
- DIMS=1, MASS=16'h4000, r_i=16'h3C00, r_j=16'h3D00, last=1 → result=16'h3E00 (1.5).
